// File: rtl/edge_refine_pkg.sv
// Shared constants for input-conditioning blocks.
// Default counter width and synchroniser depth.
package edge_refine_pkg;

    localparam int ERF_CNT_BITS    = 8;
    localparam int ERF_SYNC_STAGES = 2;
    localparam int ERF_CHANNELS    = 4;

endpackage

// File: rtl/edge_refine_multi_if.sv
// Input/output bundle of the multi-channel glitch filter.
// master drives raw inputs, slave is the filter.
interface edge_refine_multi_if #(
    parameter int CHANNELS = 4,
    parameter int CNT_BITS = 8
);
    logic                tick;
    logic [CNT_BITS-1:0] threshold;
    logic [CHANNELS-1:0] in;
    logic [CHANNELS-1:0] out;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic                any_change;

    modport master (
        output tick, threshold, in,
        input  out, rise, fall, any_change
    );

    modport slave (
        input  tick, threshold, in,
        output out, rise, fall, any_change
    );
endinterface

// File: rtl/edge_refine_channel.sv
// One filter channel: synchroniser, run counter,
// filtered level and edge pulse registers.
module edge_refine_channel #(
    parameter int   CNT_BITS    = 8,
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick,
    input  logic [CNT_BITS-1:0] teff,
    input  logic                din,
    output logic                out,
    output logic                rise,
    output logic                fall,
    output logic                flip
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [CNT_BITS-1:0]    cnt;
    logic [CNT_BITS:0]      cnt_inc;

    assign s       = sync[SYNC_STAGES-1];
    assign cnt_inc = {1'b0, cnt} + (CNT_BITS+1)'(1);
    assign flip    = (s != out) && tick &&
                     (cnt_inc >= {1'b0, teff});

    // Synchronise the raw input through a flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
        end
    end

    // Count disagreeing ticks; flip and pulse at the threshold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out  <= RESET_LEVEL;
            cnt  <= '0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (s == out) begin
                cnt <= '0;
            end else if (flip) begin
                out  <= s;
                cnt  <= '0;
                rise <= s;
                fall <= ~s;
            end else if (tick) begin
                cnt <= cnt_inc[CNT_BITS-1:0];
            end
        end
    end
endmodule

// File: rtl/edge_refine_multi.sv
// Multi-channel glitch filter with hysteresis.
// Normalises the threshold and merges edge pulses.
module edge_refine_multi
    import edge_refine_pkg::*;
#(
    parameter int   CHANNELS    = ERF_CHANNELS,
    parameter int   CNT_BITS    = ERF_CNT_BITS,
    parameter int   SYNC_STAGES = ERF_SYNC_STAGES,
    parameter logic RESET_LEVEL = 1'b0
) (
    input logic              clk,
    input logic              rst_n,
    edge_refine_multi_if.slave bus
);
    logic [CNT_BITS-1:0] teff;
    logic [CHANNELS-1:0] out_v;
    logic [CHANNELS-1:0] rise_v;
    logic [CHANNELS-1:0] fall_v;
    logic [CHANNELS-1:0] flip_v;
    logic                any_q;

    assign teff = (bus.threshold == '0) ? CNT_BITS'(1)
                                        : bus.threshold;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        edge_refine_channel #(
            .CNT_BITS    (CNT_BITS),
            .SYNC_STAGES (SYNC_STAGES),
            .RESET_LEVEL (RESET_LEVEL)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .tick  (bus.tick),
            .teff  (teff),
            .din   (bus.in[i]),
            .out   (out_v[i]),
            .rise  (rise_v[i]),
            .fall  (fall_v[i]),
            .flip  (flip_v[i])
        );
    end

    // Register the OR of all flips alongside the edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_q <= 1'b0;
        end else begin
            any_q <= |flip_v;
        end
    end

    assign bus.out        = out_v;
    assign bus.rise       = rise_v;
    assign bus.fall       = fall_v;
    assign bus.any_change = any_q;
endmodule

// File: tb/tb_edge_refine_multi.sv
// Randomised and directed bench for edge_refine_multi
// against a run-length reference model.
module tb_edge_refine_multi;
    localparam int   CH = 4;
    localparam int   CB = 8;
    localparam int   SS = 2;
    localparam logic RL = 1'b0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    edge_refine_multi_if #(.CHANNELS(CH), .CNT_BITS(CB)) bus ();

    edge_refine_multi #(
        .CHANNELS    (CH),
        .CNT_BITS    (CB),
        .SYNC_STAGES (SS),
        .RESET_LEVEL (RL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // reference model: input history queue + run length per channel
    logic [CH-1:0] hist[$];
    logic [CH-1:0] m_out, m_rise, m_fall;
    logic          m_any;
    int            m_run[CH];

    int n_rise[CH];
    int n_fall[CH];
    int n_any;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist = {};
        for (int j = 0; j < SS; j++) hist.push_back({CH{RL}});
        m_out  = {CH{RL}};
        m_rise = '0;
        m_fall = '0;
        m_any  = 1'b0;
        for (int c = 0; c < CH; c++) m_run[c] = 0;
    endtask

    task automatic model_edge();
        int teff;
        logic [CH-1:0] s;
        if (!rst_n) begin
            model_reset();
            return;
        end
        teff   = (bus.threshold == 0) ? 1 : int'(bus.threshold);
        s      = hist[SS-1];
        m_rise = '0;
        m_fall = '0;
        for (int c = 0; c < CH; c++) begin
            if (s[c] == m_out[c]) begin
                m_run[c] = 0;
            end else if (bus.tick) begin
                if (m_run[c] + 1 >= teff) begin
                    m_out[c] = s[c];
                    m_run[c] = 0;
                    if (s[c]) m_rise[c] = 1'b1;
                    else      m_fall[c] = 1'b1;
                end else begin
                    m_run[c]++;
                end
            end
        end
        m_any = |(m_rise | m_fall);
        hist.push_front(bus.in);
        void'(hist.pop_back());
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("out",  32'(bus.out),        32'(m_out));
        chk("rise", 32'(bus.rise),       32'(m_rise));
        chk("fall", 32'(bus.fall),       32'(m_fall));
        chk("any",  32'(bus.any_change), 32'(m_any));
        for (int c = 0; c < CH; c++) begin
            n_rise[c] += int'(bus.rise[c]);
            n_fall[c] += int'(bus.fall[c]);
        end
        n_any += int'(bus.any_change);
    endtask

    task automatic hold(input int n);
        repeat (n) cyc();
    endtask

    task automatic clr();
        for (int c = 0; c < CH; c++) begin
            n_rise[c] = 0;
            n_fall[c] = 0;
        end
        n_any = 0;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in        = 4'b1010;
        bus.tick      = 1'b1;
        bus.threshold = 8'd4;
        model_reset();
        clr();
        hold(3);
        chk("rst_out", 32'(bus.out), 32'h0);
        rst_n = 1'b1;
        hold(5);
        chk("rst_early", 32'(bus.out), 32'h0);
        hold(1);
        chk("rst_flip", 32'(bus.out), 32'ha);
        hold(3);
        chk("rst_r1", n_rise[1], 1);
        chk("rst_r3", n_rise[3], 1);
        chk("rst_any", n_any, 1);

        // glitch rejection
        bus.in = '0;
        hold(10);
        clr();
        bus.in[0] = 1'b1;
        hold(3);
        bus.in[0] = 1'b0;
        hold(8);
        chk("gl3_out", 32'(bus.out[0]), 0);
        chk("gl3_rise", n_rise[0], 0);
        bus.in[0] = 1'b1;
        hold(4);
        bus.in[0] = 1'b0;
        hold(10);
        chk("gl4_rise", n_rise[0], 1);
        chk("gl4_fall", n_fall[0], 1);
        chk("gl4_out", 32'(bus.out[0]), 0);

        // threshold 0 behaves as 1
        bus.threshold = 8'd0;
        bus.in[0] = 1'b1;
        hold(2);
        chk("t0_early", 32'(bus.out[0]), 0);
        hold(1);
        chk("t0_flip", 32'(bus.out[0]), 1);
        bus.in[0] = 1'b0;
        hold(5);

        // threshold 255
        bus.threshold = 8'd255;
        clr();
        bus.in[2] = 1'b1;
        hold(254);
        bus.in[2] = 1'b0;
        hold(5);
        chk("t255_254", n_rise[2], 0);
        bus.in[2] = 1'b1;
        hold(255);
        bus.in[2] = 1'b0;
        hold(4);
        chk("t255_255", n_rise[2], 1);
        bus.threshold = 8'd4;
        hold(10);
        chk("t255_back", 32'(bus.out[2]), 0);

        // tick gating, T=3, with a glitch between ticks
        bus.threshold = 8'd3;
        clr();
        bus.in[1] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            bus.tick = (i % 4 == 3);
            if (i == 8) bus.in[1] = 1'b0;
            if (i == 9) bus.in[1] = 1'b1;
            cyc();
        end
        chk("tick_rise", n_rise[1], 1);
        bus.tick  = 1'b1;
        bus.in[1] = 1'b0;
        hold(10);

        // all channels at once
        bus.threshold = 8'd4;
        clr();
        bus.in = 4'hf;
        hold(8);
        chk("conc_out", 32'(bus.out), 32'hf);
        chk("conc_any", n_any, 1);
        bus.in = '0;
        hold(10);

        // asynchronous reset mid-count
        clr();
        bus.in = 4'hf;
        hold(4);
        rst_n = 1'b0;
        #2;
        chk("mid_out", 32'(bus.out), 32'h0);
        chk("mid_pulse", 32'({bus.rise, bus.fall, bus.any_change}), 0);
        model_reset();
        bus.in = '0;
        hold(3);
        rst_n = 1'b1;
        hold(8);
        chk("mid_quiet", n_any, 0);

        // randomised traffic
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(7) == 0) bus.in[c] = ~bus.in[c];
            bus.tick = ($urandom_range(9) < 7);
            if ($urandom_range(49) == 0)
                bus.threshold = 8'($urandom_range(6));
            if ($urandom_range(499) == 0) begin
                rst_n = 1'b0;
                model_reset();
                cyc();
                rst_n = 1'b1;
            end else begin
                cyc();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
